// File: rtl/hazard_stall_unit.sv
// Stall/flush controller beside the ID stage: load-use bubbles, data-memory
// wait holds with a req/ready handshake, branch flush, stall counting, timeout.
module hazard_stall_unit #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  ID_rs1_i,
  input  logic [4:0]  ID_rs2_i,
  input  logic        ID_uses_rs2_i,
  input  logic        EX_memread_i,
  input  logic [4:0]  EX_rd_i,
  input  logic        MEM_memread_i,
  input  logic        MEM_memwrite_i,
  input  logic        dmem_ready_i,
  input  logic        branch_taken_i,
  output logic        dmem_req_o,
  output logic        PC_write_o,
  output logic        IFID_write_o,
  output logic        IFID_flush_o,
  output logic        IDEX_flush_o,
  output logic        pipe_hold_o,
  output logic        error_o,
  output logic [15:0] stall_cnt_o
);

  localparam int unsigned WAIT_W  = 16;
  localparam int unsigned STALL_W = 16;
  localparam logic [WAIT_W-1:0]  WAIT_LIMIT = WAIT_W'(TIMEOUT);
  localparam logic [STALL_W-1:0] STALL_MAX  = {STALL_W{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [WAIT_W-1:0]   wait_cnt_nxt;
  logic [STALL_W-1:0]  stall_cnt;

  logic memacc;
  logic loaduse;
  logic memstall;

  assign memacc = MEM_memread_i | MEM_memwrite_i;

  // A load in EX whose rd is a live source of the ID instruction cannot be forwarded in time.
  assign loaduse = EX_memread_i && (EX_rd_i != 5'd0) &&
                   ((EX_rd_i == ID_rs1_i) || (ID_uses_rs2_i && (EX_rd_i == ID_rs2_i)));

  assign memstall = ((state == ST_RUN) && memacc && !dmem_ready_i) ||
                    ((state == ST_MEM_WAIT) && !dmem_ready_i) ||
                    (state == ST_ERROR);

  // State, wait counter and stall counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (!PC_write_o && (stall_cnt != STALL_MAX)) begin
        stall_cnt <= stall_cnt + STALL_W'(1);
      end
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      ST_RUN: begin
        if (memacc && !dmem_ready_i) begin
          state_nxt    = ST_MEM_WAIT;
          wait_cnt_nxt = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ready_i) begin
          state_nxt    = ST_RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt >= WAIT_LIMIT) begin
          state_nxt = ST_ERROR;
        end else begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      ST_ERROR: begin
        state_nxt = ST_ERROR;
      end
      default: begin
        state_nxt    = ST_RUN;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  // Output decode: memory hold beats the load-use bubble, which beats the branch flush.
  always_comb begin
    dmem_req_o   = 1'b0;
    PC_write_o   = 1'b1;
    IFID_write_o = 1'b1;
    IFID_flush_o = 1'b0;
    IDEX_flush_o = 1'b0;
    pipe_hold_o  = 1'b0;
    error_o      = 1'b0;
    stall_cnt_o  = '0;
    if (!rst_i) begin
      dmem_req_o  = ((state == ST_RUN) && memacc) || (state == ST_MEM_WAIT);
      error_o     = (state == ST_ERROR);
      stall_cnt_o = stall_cnt;
      if (memstall) begin
        pipe_hold_o  = 1'b1;
        PC_write_o   = 1'b0;
        IFID_write_o = 1'b0;
      end else if (loaduse) begin
        PC_write_o   = 1'b0;
        IFID_write_o = 1'b0;
        IDEX_flush_o = 1'b1;
      end else begin
        IFID_flush_o = branch_taken_i;
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: a rule-level model checked every cycle
// plus hand-computed expectations at the interesting points of each scenario.
module tb_hazard_stall_unit;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rs1 = '0, rs2 = '0, exrd = '0;
  logic        u2 = 1'b0, exmr = 1'b0, mr = 1'b0, mw = 1'b0, rdy = 1'b0, br = 1'b0;

  logic        dmem_req, pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, error;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: 0 = RUN, 1 = MEM_WAIT, 2 = ERROR
  int mode = 0;
  int wcnt = 0;
  int scnt = 0;
  logic [6:0] o_pos;

  hazard_stall_unit #(.TIMEOUT(TO)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ID_rs1_i       (rs1),
    .ID_rs2_i       (rs2),
    .ID_uses_rs2_i  (u2),
    .EX_memread_i   (exmr),
    .EX_rd_i        (exrd),
    .MEM_memread_i  (mr),
    .MEM_memwrite_i (mw),
    .dmem_ready_i   (rdy),
    .branch_taken_i (br),
    .dmem_req_o     (dmem_req),
    .PC_write_o     (pc_write),
    .IFID_write_o   (ifid_write),
    .IFID_flush_o   (ifid_flush),
    .IDEX_flush_o   (idex_flush),
    .pipe_hold_o    (pipe_hold),
    .error_o        (error),
    .stall_cnt_o    (stall_cnt)
  );

  always #5 clk = ~clk;

  // Expected {req, pc_write, ifid_write, ifid_flush, idex_flush, hold, error}
  function automatic logic [6:0] calc_out();
    logic memacc, lu, ms, req, err;
    if (rst) return 7'b0110000;
    memacc = mr | mw;
    lu  = exmr && (exrd != 0) && ((exrd == rs1) || (u2 && (exrd == rs2)));
    ms  = (mode == 0 && memacc && !rdy) || (mode == 1 && !rdy) || (mode == 2);
    req = (mode == 0 && memacc) || (mode == 1);
    err = (mode == 2);
    if (ms)      return {req, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, err};
    else if (lu) return {req, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, err};
    else         return {req, 1'b1, 1'b1, br,   1'b0, 1'b0, err};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at each rising edge.
  always @(posedge clk) begin
    o_pos = calc_out();
    if (rst) begin
      mode <= 0;
      wcnt <= 0;
      scnt <= 0;
    end else begin
      if (!o_pos[5] && scnt < 65535) scnt <= scnt + 1;
      case (mode)
        0: if ((mr | mw) && !rdy) begin mode <= 1; wcnt <= 1; end
        1: begin
          if (rdy) begin mode <= 0; wcnt <= 0; end
          else if (wcnt >= TO) mode <= 2;
          else wcnt <= wcnt + 1;
        end
        default: mode <= 2;
      endcase
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    check("model_outputs",
          16'({dmem_req, pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, error}),
          16'(calc_out()));
    check("model_stall_cnt", stall_cnt, rst ? 16'h0 : 16'(scnt));
  end

  task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic use2,
                       input logic exl, input logic [4:0] rd, input logic mrd,
                       input logic mwr, input logic ready, input logic brt);
    rs1 = r1; rs2 = r2; u2 = use2; exmr = exl; exrd = rd;
    mr = mrd; mw = mwr; rdy = ready; br = brt;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_pc_write", 16'(pc_write), 16'h1);
    check("rst_stall_cnt", stall_cnt, 16'h0);
    adv();
    rst = 1'b0;

    // Load x5 in EX, add x6,x5,x1 in ID
    drive(5, 1, 1, 1, 5, 0, 0, 1, 0);
    check("lu_pc_write", 16'(pc_write), 16'h0);
    check("lu_idex_flush", 16'(idex_flush), 16'h1);
    adv();
    drive(5, 1, 1, 0, 0, 1, 0, 1, 0);
    check("lu_after_pc_write", 16'(pc_write), 16'h1);
    check("lu_after_stall_cnt", stall_cnt, 16'h1);
    check("lu_after_req", 16'(dmem_req), 16'h1);
    check("lu_after_hold", 16'(pipe_hold), 16'h0);
    adv();

    // EX rd = x0 never stalls
    drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
    check("x0_pc_write", 16'(pc_write), 16'h1);
    adv();

    // Store with rs2 = x5: stall only when rs2 is used
    drive(2, 5, 0, 1, 5, 0, 0, 0, 0);
    check("rs2_unused_pc_write", 16'(pc_write), 16'h1);
    adv();
    drive(2, 5, 1, 1, 5, 0, 0, 0, 0);
    check("rs2_used_pc_write", 16'(pc_write), 16'h0);
    adv();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rs2_stall_cnt", stall_cnt, 16'h2);
    adv();

    // MEM load waits 4 cycles with a pending load-use that must wait too
    for (int i = 0; i < 4; i++) begin
      drive(5, 0, 0, 1, 5, 1, 0, 0, 0);
      check("wait_req", 16'(dmem_req), 16'h1);
      check("wait_hold", 16'(pipe_hold), 16'h1);
      check("wait_idex_flush", 16'(idex_flush), 16'h0);
      adv();
    end
    drive(5, 0, 0, 1, 5, 1, 0, 1, 0);
    check("ready_req", 16'(dmem_req), 16'h1);
    check("ready_hold", 16'(pipe_hold), 16'h0);
    check("ready_bubble", 16'(idex_flush), 16'h1);
    check("ready_stall_cnt", stall_cnt, 16'h6);
    adv();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("post_wait_stall_cnt", stall_cnt, 16'h7);
    check("post_wait_req", 16'(dmem_req), 16'h0);
    adv();

    // Branch suppressed by load-use, re-evaluated next cycle
    drive(7, 0, 0, 1, 7, 0, 0, 0, 1);
    check("br_lu_flush", 16'(ifid_flush), 16'h0);
    check("br_lu_pc_write", 16'(pc_write), 16'h0);
    adv();
    drive(7, 0, 0, 0, 0, 0, 0, 0, 1);
    check("br_flush", 16'(ifid_flush), 16'h1);
    check("br_pc_write", 16'(pc_write), 16'h1);
    adv();

    // Stray ready, then a zero-wait store
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    check("stray_ready_req", 16'(dmem_req), 16'h0);
    check("stray_ready_hold", 16'(pipe_hold), 16'h0);
    adv();
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
    check("fast_req", 16'(dmem_req), 16'h1);
    check("fast_hold", 16'(pipe_hold), 16'h0);
    check("fast_stall_cnt", stall_cnt, 16'h8);
    adv();

    // Timeout: RUN request cycle plus TO wait cycles, then ERROR
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
      check("to_error_low", 16'(error), 16'h0);
      check("to_req", 16'(dmem_req), 16'h1);
      adv();
    end
    drive(0, 0, 0, 0, 0, 1, 0, 1, 0);
    check("err_error", 16'(error), 16'h1);
    check("err_req", 16'(dmem_req), 16'h0);
    check("err_hold", 16'(pipe_hold), 16'h1);
    check("err_stall_cnt", stall_cnt, 16'd13);
    adv();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("err_rst_pc_write", 16'(pc_write), 16'h1);
    check("err_rst_error", 16'(error), 16'h0);
    adv();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("post_rst_stall_cnt", stall_cnt, 16'h0);
    check("post_rst_error", 16'(error), 16'h0);
    check("post_rst_hold", 16'(pipe_hold), 16'h0);
    adv();

    // Saturation: sit in ERROR for 70000 cycles
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    repeat (70000) adv();
    @(negedge clk);
    check("sat_stall_cnt", stall_cnt, 16'hFFFF);
    check("sat_hold", 16'(pipe_hold), 16'h1);
    adv();
    adv();
    @(negedge clk);
    check("sat_stays", stall_cnt, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
